// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// The master drives a request and holds it while busy_o is high; the slave answers.
interface dmem_if;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i,
    output busy_o, rvalid_o, rdata_o, err_o
  );

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i,
    input  busy_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: one load/store per request, serviced after WAIT_CYCLES
// wait states, with byte/half/word lane handling, load extension and misalignment errors.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  dmem_if.slave  bus
);
  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_err;

  logic          w_busy, w_take, w_enter_done;
  logic          w_we, w_err;
  logic [2:0]    w_funct3;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane, w_word, w_load_val;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_unused;

  assign w_unused = ^bus.addr_i[31:AW+2];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_i) begin
        w_busy = 1'b1;
        w_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt <= 4'd1) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_take       = (r_state == S_IDLE) && bus.req_i;
  assign w_enter_done = (w_next == S_DONE) && reset_n;

  // With zero wait states the access completes straight from the live request.
  assign w_we     = (r_state == S_IDLE) ? bus.we_i             : r_we;
  assign w_funct3 = (r_state == S_IDLE) ? bus.funct3_i         : r_funct3;
  assign w_addr   = (r_state == S_IDLE) ? bus.addr_i[AW+1:0]   : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? bus.wdata_i          : r_wdata;
  assign w_off    = w_addr[1:0];
  assign w_idx    = w_addr[AW+1:2];

  always_comb begin
    w_err   = 1'b0;
    w_be    = 4'b1111;
    w_wlane = w_wdata;
    case (w_funct3)
      3'b000, 3'b100: w_err = 1'b0;
      3'b001, 3'b101: w_err = w_off[0];
      3'b010:         w_err = |w_off;
      default:        w_err = 1'b1;
    endcase
    case (w_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wlane = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = w_word;
    endcase
  end

  // NOTE: the array has no reset; clearing it would force a flop-based memory.
  always_ff @(posedge clk) begin
    if (w_enter_done && w_we && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
    end else if (w_take) begin
      r_cnt    <= WAIT_LD;
      r_we     <= bus.we_i;
      r_funct3 <= bus.funct3_i;
      r_addr   <= bus.addr_i[AW+1:0];
      r_wdata  <= bus.wdata_i;
    end else if (r_state == S_WAIT) begin
      r_cnt    <= r_cnt - 4'd1;
    end
  end

  // Response pulses are valid only in DONE; rdata_o holds until the next completed load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else if (w_enter_done) begin
      r_rvalid <= !w_we;
      r_err    <= w_err;
      if (w_err)      r_rdata <= 32'd0;
      else if (!w_we) r_rdata <= w_load_val;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end
  end

  assign bus.busy_o   = w_busy;
  assign bus.rvalid_o = r_rvalid;
  assign bus.err_o    = r_err;
  assign bus.rdata_o  = r_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  typedef struct {
    logic        rv;
    logic        er;
    logic [31:0] rd;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  exp_t m_e2, m_e0;

  dmem_if if2();
  dmem_if if0();

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2.slave));
  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Response monitor: every rvalid/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (if2.rvalid_o || if2.err_o) begin
        if (q2.size() == 0) check("w2_unexpected_pulse", {30'd0, if2.rvalid_o, if2.err_o}, 32'd0);
        else begin
          m_e2 = q2.pop_front();
          check("w2_rvalid", {31'd0, if2.rvalid_o}, {31'd0, m_e2.rv});
          check("w2_err", {31'd0, if2.err_o}, {31'd0, m_e2.er});
          check("w2_rdata", if2.rdata_o, m_e2.rd);
        end
      end
      if (if0.rvalid_o || if0.err_o) begin
        if (q0.size() == 0) check("w0_unexpected_pulse", {30'd0, if0.rvalid_o, if0.err_o}, 32'd0);
        else begin
          m_e0 = q0.pop_front();
          check("w0_rvalid", {31'd0, if0.rvalid_o}, {31'd0, m_e0.rv});
          check("w0_err", {31'd0, if0.err_o}, {31'd0, m_e0.er});
          check("w0_rdata", if0.rdata_o, m_e0.rd);
        end
      end
    end
  end

  task automatic drive(input bit zw, input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (zw) begin
      if0.req_i = req; if0.we_i = we; if0.funct3_i = f3; if0.addr_i = a; if0.wdata_i = wd;
    end else begin
      if2.req_i = req; if2.we_i = we; if2.funct3_i = f3; if2.addr_i = a; if2.wdata_i = wd;
    end
  endtask

  // One full access; zw selects the zero-wait instance. Expectations go to the scoreboard.
  task automatic access(input bit zw, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    int   n_busy;
    logic b;
    exp_t e;
    if (!we || exp_err) begin
      e.rv = !we;
      e.er = exp_err;
      e.rd = exp_err ? 32'd0 : exp_rd;
      if (zw) q0.push_back(e);
      else    q2.push_back(e);
    end
    @(posedge clk); #1;
    drive(zw, 1'b1, we, f3, a, wd);
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      b = zw ? if0.busy_o : if2.busy_o;
      if (!b) break;
      n_busy++;
    end
    check(zw ? "w0_busy_len" : "w2_busy_len", n_busy, zw ? 32'd1 : 32'd3);
    drive(zw, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check(zw ? "w0_pulse_end" : "w2_pulse_end",
          zw ? {30'd0, if0.rvalid_o, if0.err_o} : {30'd0, if2.rvalid_o, if2.err_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #12;
    check("rst_busy", {31'd0, if2.busy_o}, 32'd0);
    check("rst_rvalid", {31'd0, if2.rvalid_o}, 32'd0);
    check("rst_err", {31'd0, if2.err_o}, 32'd0);
    check("rst_rdata", if2.rdata_o, 32'd0);
    check("rst_rdata0", if0.rdata_o, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Word store/load, then byte lanes and extension.
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, 32'd0, 1'b0);
    access(1'b0, 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
    access(1'b0, 1'b0, 3'b100, 32'h13, 32'd0, 32'h00000080, 1'b0);
    access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0);

    // Misaligned half store must not write; halfword loads.
    access(1'b0, 1'b1, 3'b001, 32'h11, 32'h00001234, 32'd0, 1'b1);
    access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0);
    access(1'b0, 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF80AD, 1'b0);
    access(1'b0, 1'b0, 3'b101, 32'h12, 32'd0, 32'h000080AD, 1'b0);
    access(1'b0, 1'b1, 3'b001, 32'h16, 32'h0000A5C3, 32'd0, 1'b0);
    access(1'b0, 1'b0, 3'b101, 32'h16, 32'd0, 32'h0000A5C3, 1'b0);
    access(1'b0, 1'b0, 3'b010, 32'h16, 32'd0, 32'd0, 1'b1);

    // Reset during WAIT aborts the pending store.
    access(1'b0, 1'b1, 3'b010, 32'h20, 32'h00000001, 32'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h00000002);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    check("abort_busy", {31'd0, if2.busy_o}, 32'd0);
    check("abort_rvalid", {31'd0, if2.rvalid_o}, 32'd0);
    check("abort_rdata", if2.rdata_o, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    access(1'b0, 1'b0, 3'b010, 32'h20, 32'd0, 32'h00000001, 1'b0);

    // Address wrap modulo DEPTH_WORDS*4.
    access(1'b0, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'd0, 1'b0);
    access(1'b0, 1'b0, 3'b010, 32'h0, 32'd0, 32'hCAFEF00D, 1'b0);

    // Zero-wait instance: back-to-back loads and an illegal funct3.
    access(1'b1, 1'b1, 3'b010, 32'h8, 32'h13579BDF, 32'd0, 1'b0);
    access(1'b1, 1'b1, 3'b010, 32'hC, 32'h2468ACE0, 32'd0, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h8, 32'd0, 32'h13579BDF, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'hC, 32'd0, 32'h2468ACE0, 1'b0);
    access(1'b1, 1'b0, 3'b000, 32'hF, 32'd0, 32'h00000024, 1'b0);
    access(1'b1, 1'b0, 3'b011, 32'h8, 32'd0, 32'd0, 1'b1);

    repeat (3) @(negedge clk);
    check("w2_sb_left", q2.size(), 32'd0);
    check("w0_sb_left", q0.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
